// File: rtl/signed_pow2_divide_sequencer.sv
// Multi-cycle signed power-of-two shifter/divider.
// A single 1-bit arithmetic-shift step is applied once per cycle; divide mode
// inserts one bias-add cycle for negative operands so the floor shift becomes
// round-toward-zero.
module signed_pow2_divide_sequencer #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIAS  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SW-1:0] K_LIM = SW'(N);
  localparam logic [SW-1:0] K_MAX = SW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [SW-1:0] k_sat;

  // Next-state, datapath step and registered-output precompute
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_sat       = (in_shamt >= K_LIM) ? K_MAX : in_shamt;
    out_valid_d = 1'b0;
    in_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mode && (in_shamt >= K_LIM)) begin
            // Any N-bit value divided by 2^N truncates to zero
            acc_d   = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            acc_d = in_data;
            cnt_d = k_sat;
            if (k_sat == '0) begin
              state_d = DONE;
            end else if (in_mode && in_data[N-1]) begin
              state_d = BIAS;
            end else begin
              state_d = SHIFT;
            end
          end
        end
      end
      BIAS: begin
        // acc is negative and k <= N-1, so adding 2^k-1 cannot overflow
        acc_d   = acc_q + ((N'(1) << cnt_q) - N'(1));
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {acc_q[N-1], acc_q[N-1:1]};
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_signed_pow2_divide_sequencer.sv
// Bench for signed_pow2_divide_sequencer (N=8): directed table, backpressure,
// mid-operation reset and randomized traffic against an arithmetic model.
module tb_signed_pow2_divide_sequencer;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  int checks = 0;
  int errors = 0;

  signed_pow2_divide_sequencer #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  data;
    logic [SW-1:0] shamt;
    logic          mode;
    logic [N-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  // Reference: plain signed arithmetic on integers
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] d,
                                              input logic [SW-1:0] k,
                                              input logic mode);
    int sd;
    int kk;
    int r;
    sd = int'(signed'(d));
    kk = int'(k);
    if (!mode) begin
      if (kk >= N) kk = N - 1;
      r = sd >>> kk;
    end else if (kk >= N) begin
      r = 0;
    end else begin
      r = sd / (1 << kk);
    end
    return r[N-1:0];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, measure latency, check result, then complete handshake
  task automatic run_op(input string name, input logic [N-1:0] d,
                        input logic [SW-1:0] k, input logic mode,
                        input logic [N-1:0] exp_d, input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    chk({name, "_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = k;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_data"}, int'(out_data), int'(exp_d));
    if (exp_lat > 0) chk({name, "_lat"}, lat, exp_lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_drop"}, int'(out_valid), 0);
  endtask

  vec_t vecs[$];
  logic [N-1:0] exp_q[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_valid_post", int'(out_valid), 0);

    // Directed table
    vecs.push_back('{8'hE5, 4'd3,  1'b0, 8'hFC, 4});
    vecs.push_back('{8'hE5, 4'd3,  1'b1, 8'hFD, 5});
    vecs.push_back('{8'h1B, 4'd3,  1'b1, 8'h03, 4});
    vecs.push_back('{8'h5A, 4'd0,  1'b0, 8'h5A, 1});
    vecs.push_back('{8'hA5, 4'd0,  1'b1, 8'hA5, 1});
    vecs.push_back('{8'h80, 4'd9,  1'b0, 8'hFF, 8});
    vecs.push_back('{8'h80, 4'd7,  1'b1, 8'hFF, 9});
    vecs.push_back('{8'h80, 4'd8,  1'b1, 8'h00, 1});
    vecs.push_back('{8'h7F, 4'd7,  1'b1, 8'h00, 8});
    vecs.push_back('{8'h81, 4'd7,  1'b0, 8'hFF, 8});
    vecs.push_back('{8'hFF, 4'd1,  1'b1, 8'h00, 3});
    vecs.push_back('{8'h80, 4'd15, 1'b0, 8'hFF, 8});
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt,
             vecs[i].mode, vecs[i].exp_data, vecs[i].exp_lat);
    end

    // Backpressure: result held while out_ready is low, commands ignored
    run_op("bp_pre", 8'h40, 4'd2, 1'b0, 8'h10, 3);
    in_valid = 1'b1;
    in_data  = 8'hE5;
    in_shamt = 4'd3;
    in_mode  = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_shamt = 4'd0;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 8'hFC);
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_extra", int'(out_valid), 0);
    end

    // Reset mid-SHIFT discards the operation
    in_valid = 1'b1;
    in_data  = 8'h40;
    in_shamt = 4'd5;
    in_mode  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", int'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_no_out", int'(out_valid), 0);
    end
    run_op("post_rst", 8'hF9, 4'd1, 1'b1, 8'hFD, 3);

    // Randomized traffic with random backpressure, in-order scoreboard
    begin
      int accepted;
      int cyc;
      logic [N-1:0] e;
      accepted = 0;
      cyc = 0;
      while ((accepted < 2000 || exp_q.size() > 0) && cyc < 60000) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rand_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rand_data", int'(out_data), int'(e));
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_result(in_data, in_shamt, in_mode));
          accepted++;
        end
        tick();
        cyc++;
        in_valid  = (accepted < 2000) && ($urandom_range(0, 2) != 0);
        in_data   = N'($urandom);
        in_shamt  = SW'($urandom_range(0, 15));
        in_mode   = 1'($urandom);
        out_ready = 1'($urandom);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("rand_accepted", accepted, 2000);
      chk("rand_drained", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
